fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmit stage that drains the byte FIFO. When the FIFO is non-empty and transmission is enabled, it issues single-cycle read strobes and captures each byte. It then shifts the byte out on a UART line as 8N1: one start bit, 8 data bits LSB first, one stop bit. It sits directly downstream of the FIFO's read port, and its `tx` pin drives the board serial line.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868, clock cycles per serial bit (100 MHz / 115200). Must be ≥ 2.
- `WIDTH`, default 8, data width. Fixed at 8 for 8N1 framing.

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `tx_enable`  in  1  permits new frames to start
- `fifo_empty`  in  1  FIFO has no readable byte
- `fifo_rd_en`  out  1  registered one-cycle read strobe to the FIFO
- `fifo_rd_data`  in  WIDTH  FIFO read data, registered in the FIFO, valid the cycle after `fifo_rd_en`
- `tx`  out  1  serial line, idle high, registered
- `busy`  out  1  high from FETCH through the end of STOP
- `frame_done`  out  1  one-cycle pulse on the last cycle of STOP

## Operation
- Reset: one clock; `rst` is asynchronous and active-high. All flops clear immediately.
- Reset values: `tx`=1, `fifo_rd_en`=0, `busy`=0, `frame_done`=0, state=IDLE, counters=0.
- States are IDLE, FETCH, WAIT, START, DATA and STOP.
- IDLE → FETCH when `tx_enable` && !`fifo_empty`. Otherwise remain in IDLE.
- FETCH lasts exactly 1 cycle with `fifo_rd_en`=1, then → WAIT.
- WAIT lasts 1 cycle. At the edge that leaves WAIT, `fifo_rd_data` is loaded into the shift register, `tx` is driven 0, and the state → START.
- START holds `tx`=0 for `CLKS_PER_BIT` cycles, then → DATA.
- DATA outputs bits 0..7 of the shift register, each held `CLKS_PER_BIT` cycles. The bit index counts 0..7, and after bit 7 the state → STOP.
- STOP holds `tx`=1 for `CLKS_PER_BIT` cycles. `frame_done`=1 on its final cycle, then → IDLE.
- Baud counter:
  - Width is $clog2(`CLKS_PER_BIT`).
  - It counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every bit boundary.
  - It never wraps mid-bit.
- Bit index: 3 bits. Cleared on entry to DATA.
- `tx_enable` deasserted mid-frame: the current frame completes normally. No new FETCH is issued while it is low.
- `fifo_empty` is sampled only in IDLE. A FIFO that becomes empty mid-frame has no effect on the frame in flight.
- Empty FIFO: no read is ever issued while `fifo_empty`=1. This guarantees no underflow read.
- `rst` mid-frame: `tx` returns to 1 asynchronously and the in-flight byte is discarded, with no partial retry. After reset, the next FETCH occurs only on a fresh IDLE evaluation.

## Timing
- Read latency: from edge E0 (IDLE with a non-empty FIFO), `fifo_rd_en` is high during cycle E0→E1. Data is captured at E2, and `tx` falls at E2.
- Frame length: the line is low/high for exactly 10×`CLKS_PER_BIT` cycles, start bit through end of stop bit.
- Back-to-back frames:
  - The next FETCH begins at the first IDLE edge.
  - The minimum idle-high gap between stop bit and next start bit is 3 cycles (IDLE, FETCH, WAIT).
  - The repeat period is 10×`CLKS_PER_BIT`+3 cycles.
- `busy` rises at E0 and falls at the STOP→IDLE edge.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum: IDLE, FETCH, WAIT, START, DATA, STOP;
  - `UART_DATA_BITS`=8;
  - default `CLKS_PER_BIT`.
- One natural sub-module, `uart_baud_counter`. It takes `clk`/`rst`, a clear input and a count-enable, and outputs a `bit_tick` pulse when the count reaches `CLKS_PER_BIT`-1.
- The FSM, shift register and bit index live in the top module.

## Test plan
Use `CLKS_PER_BIT`=4 in simulation, giving a frame of 40 cycles.
- Reset/idle: hold `rst`=1, then release with `fifo_empty`=1 for 100 cycles → `tx`=1, `fifo_rd_en`=0, `busy`=0 throughout.
- Single byte: preload 8'hA5 and deassert `fifo_empty` → one `fifo_rd_en` pulse. `tx` waveform, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1. `frame_done` pulses once, 40 cycles after `tx` falls.
- Back-to-back: FIFO holds 8'h00, 8'hFF, 8'h55 → exactly 3 read strobes, 43 cycles apart. Decoded bytes match in order. The gap between stop bit and next start bit is 3 cycles high.
- `tx_enable` drop: deassert during bit 3 of 8'h3C → the frame completes correctly and no further `fifo_rd_en` occurs while `tx_enable`=0. Re-enabling resumes with the next byte.
- Reset mid-frame: assert `rst` during bit 5 → `tx`=1 in the same cycle and `busy`=0. After release with the FIFO non-empty, the next byte transmits as a full, correct frame.
- Underflow guard: toggle `fifo_empty` randomly. The checker asserts `fifo_rd_en` is never high in a cycle whose preceding IDLE sample saw `fifo_empty`=1, and that each frame's bits match the byte read.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states and framing constants.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      START,
      DATA,
      STOP
   } uart_state_e;

   localparam int UART_DATA_BITS    = 8;
   localparam int UART_CLKS_PER_BIT = 868;  // 100 MHz / 115200 baud

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic bit_tick,
   output logic pre_tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

   logic [CNT_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + CNT_W'(1);
      end
   end

   // pre_tick lets the parent register a pulse that lands on the final cycle of the bit.
   assign bit_tick = enable && (count == LAST);
   assign pre_tick = enable && (count == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO and serialises each byte as an 8N1 UART frame on a registered tx line.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int WIDTH        = UART_DATA_BITS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_enable,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic [WIDTH-1:0] fifo_rd_data,
   output logic             tx,
   output logic             busy,
   output logic             frame_done
);

   localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

   uart_state_e      state, state_nx;
   logic [WIDTH-1:0] shift_q, shift_nx;
   logic [2:0]       bit_idx, bit_idx_nx;
   logic             tx_nx, rd_en_nx, busy_nx, done_nx;
   logic             bit_tick, pre_tick;
   logic             baud_clear, baud_en;

   assign baud_clear = (state == WAIT);
   assign baud_en    = (state == START) || (state == DATA) || (state == STOP);

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk     (clk),
      .rst     (rst),
      .clear   (baud_clear),
      .enable  (baud_en),
      .bit_tick(bit_tick),
      .pre_tick(pre_tick)
   );

   // NOTE: every variable gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_nx   = state;
      shift_nx   = shift_q;
      bit_idx_nx = bit_idx;
      tx_nx      = tx;
      rd_en_nx   = 1'b0;
      busy_nx    = busy;
      done_nx    = 1'b0;
      case (state)
         IDLE: begin
            if (tx_enable && !fifo_empty) begin
               state_nx = FETCH;
               rd_en_nx = 1'b1;
               busy_nx  = 1'b1;
            end
         end
         FETCH: state_nx = WAIT;
         WAIT: begin
            // FIFO data is valid now, one cycle after the read strobe.
            state_nx = START;
            shift_nx = fifo_rd_data;
            tx_nx    = 1'b0;
         end
         START: begin
            if (bit_tick) begin
               state_nx   = DATA;
               bit_idx_nx = '0;
               tx_nx      = shift_q[0];
            end
         end
         DATA: begin
            if (bit_tick) begin
               if (bit_idx == LAST_BIT) begin
                  state_nx = STOP;
                  tx_nx    = 1'b1;
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
                  tx_nx      = shift_q[bit_idx_nx];
               end
            end
         end
         STOP: begin
            done_nx = pre_tick;
            if (bit_tick) begin
               state_nx = IDLE;
               busy_nx  = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: the shift register is a handful of flops with no RAM behind it, so it is reset with the rest.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shift_q    <= '0;
         bit_idx    <= '0;
         tx         <= 1'b1;
         fifo_rd_en <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         shift_q    <= shift_nx;
         bit_idx    <= bit_idx_nx;
         tx         <= tx_nx;
         fifo_rd_en <= rd_en_nx;
         busy       <= busy_nx;
         frame_done <= done_nx;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised self-checking bench: FIFO model plus a UART line decoder acting as reference.
module tb_fifo_uart_tx;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tx_enable = 1'b0;
   logic       fifo_empty = 1'b1;
   logic       fifo_rd_en;
   logic [7:0] fifo_rd_data = 8'h00;
   logic       tx, busy, frame_done;

   logic       force_empty = 1'b1;
   logic [7:0] fifo_q[$];
   logic [7:0] read_q[$];
   logic [7:0] decoded_q[$];
   logic [7:0] expect_seq[$];
   int         rd_cycles[$];
   int         start_cycles[$];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .CLKS_PER_BIT(CPB),
      .WIDTH       (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .tx_enable   (tx_enable),
      .fifo_empty  (fifo_empty),
      .fifo_rd_en  (fifo_rd_en),
      .fifo_rd_data(fifo_rd_data),
      .tx          (tx),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- FIFO model and line monitor (negedge, away from the active edge)
   int         cyc = 0;
   int         last_rd_cyc = -100;
   int         idx = 0;
   int         frame_count = 0;
   logic       in_frame = 1'b0;
   logic       rd_allowed = 1'b0;
   logic       prev_rd_en = 1'b0;
   logic       busy_all;
   logic [39:0] wave, dwave, exp_w, exp_d;
   logic [7:0] exp_b, dec_b;
   logic       bitv;

   always @(negedge clk) begin
      cyc++;
      if (fifo_rd_en) begin
         check("rd_allowed", 64'(rd_allowed), 64'(1));
         check("rd_single", 64'(prev_rd_en), 64'(0));
         check("busy_at_rd", 64'(busy), 64'(1));
         if (fifo_q.size() > 0) begin
            fifo_rd_data = fifo_q.pop_front();
            read_q.push_back(fifo_rd_data);
         end
         rd_cycles.push_back(cyc);
         last_rd_cyc = cyc;
      end
      prev_rd_en = fifo_rd_en;
      fifo_empty = force_empty || (fifo_q.size() == 0);
      rd_allowed = tx_enable && !fifo_empty && !rst;

      if (rst) begin
         in_frame = 1'b0;
         read_q.delete();
      end else if (in_frame) begin
         wave[idx]  = tx;
         dwave[idx] = frame_done;
         busy_all   = busy_all & busy;
         idx++;
         if (idx == FRAME) begin
            in_frame = 1'b0;
            if (read_q.size() == 0) begin
               check("frame_without_read", 64'(0), 64'(1));
               exp_b = 8'h00;
            end else begin
               exp_b = read_q.pop_front();
            end
            for (int b = 0; b < 10; b++) begin
               if (b == 0) bitv = 1'b0;
               else if (b == 9) bitv = 1'b1;
               else bitv = exp_b[b-1];
               for (int c = 0; c < CPB; c++) exp_w[b*CPB+c] = bitv;
            end
            exp_d = '0;
            exp_d[FRAME-1] = 1'b1;
            check("frame_wave", 64'(wave), 64'(exp_w));
            check("frame_done_pos", 64'(dwave), 64'(exp_d));
            check("frame_busy", 64'(busy_all), 64'(1));
            for (int i = 0; i < 8; i++) dec_b[i] = wave[(i+1)*CPB + CPB/2];
            decoded_q.push_back(dec_b);
            frame_count++;
         end
      end else begin
         if (frame_done) check("done_outside_frame", 64'(frame_done), 64'(0));
         if (tx == 1'b0) begin
            in_frame = 1'b1;
            wave     = '0;
            dwave    = '0;
            wave[0]  = tx;
            dwave[0] = frame_done;
            busy_all = busy;
            idx      = 1;
            start_cycles.push_back(cyc);
            check("start_latency", 64'(cyc - last_rd_cyc), 64'(2));
         end
      end
   end

   // ---------------- stimulus helpers (inputs change 2 time units after the rising edge)
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_frames(input int target, input int budget, input string tag);
      int k = 0;
      while (frame_count < target && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, 64'(frame_count >= target), 64'(1));
   endtask

   task automatic wait_idx(input int target, input int budget, input string tag);
      int k = 0;
      while (!(in_frame && idx == target) && k < budget) begin
         tick(1);
         k++;
      end
      check(tag, 64'(in_frame && idx == target), 64'(1));
   endtask

   task automatic expect_byte(input string tag, input logic [7:0] b);
      if (decoded_q.size() == 0) check(tag, 64'(0), 64'(b) | 64'h100);
      else check(tag, 64'(decoded_q.pop_front()), 64'(b));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, s0, f0, k;
      logic [7:0] rb;

      // Reset and idle with an empty FIFO
      tick(3);
      check("reset_values", 64'({tx, fifo_rd_en, busy, frame_done}), 64'(4'b1000));
      rst = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick(1);
         check("idle_outputs", 64'({tx, fifo_rd_en, busy}), 64'(3'b100));
      end

      // Single byte
      tx_enable = 1'b1;
      n0 = rd_cycles.size();
      fifo_q.push_back(8'hA5);
      force_empty = 1'b0;
      wait_frames(frame_count + 1, 200, "single_timeout");
      tick(10);
      check("single_rd_count", 64'(rd_cycles.size() - n0), 64'(1));
      expect_byte("single_byte", 8'hA5);

      // Back-to-back
      n0 = rd_cycles.size();
      s0 = start_cycles.size();
      fifo_q.push_back(8'h00);
      fifo_q.push_back(8'hFF);
      fifo_q.push_back(8'h55);
      wait_frames(frame_count + 3, 400, "b2b_timeout");
      tick(20);
      check("b2b_rd_count", 64'(rd_cycles.size() - n0), 64'(3));
      if (rd_cycles.size() - n0 == 3 && start_cycles.size() - s0 == 3) begin
         for (int i = 0; i < 2; i++) begin
            check("b2b_rd_period", 64'(rd_cycles[n0+i+1] - rd_cycles[n0+i]), 64'(FRAME + 3));
            check("b2b_start_period", 64'(start_cycles[s0+i+1] - start_cycles[s0+i]), 64'(FRAME + 3));
         end
      end
      expect_byte("b2b_byte0", 8'h00);
      expect_byte("b2b_byte1", 8'hFF);
      expect_byte("b2b_byte2", 8'h55);

      // tx_enable dropped during data bit 3
      f0 = frame_count;
      fifo_q.push_back(8'h3C);
      fifo_q.push_back(8'h77);
      wait_idx(4 * CPB + 1, 200, "en_drop_reach");
      tx_enable = 1'b0;
      wait_frames(f0 + 1, 200, "en_drop_timeout");
      n0 = rd_cycles.size();
      tick(100);
      check("en_drop_no_read", 64'(rd_cycles.size() - n0), 64'(0));
      check("en_drop_no_frame", 64'(frame_count), 64'(f0 + 1));
      expect_byte("en_drop_byte", 8'h3C);
      tx_enable = 1'b1;
      wait_frames(f0 + 2, 200, "en_resume_timeout");
      expect_byte("en_resume_byte", 8'h77);
      tick(10);

      // Reset during data bit 5
      f0 = frame_count;
      fifo_q.push_back(8'h12);
      fifo_q.push_back(8'h34);
      wait_idx(6 * CPB + 1, 200, "rst_reach");
      rst = 1'b1;
      #1;
      check("rst_async_outputs", 64'({tx, busy, fifo_rd_en}), 64'(3'b100));
      tick(2);
      rst = 1'b0;
      wait_frames(f0 + 1, 200, "rst_recover_timeout");
      check("rst_frame_count", 64'(frame_count), 64'(f0 + 1));
      expect_byte("rst_next_byte", 8'h34);
      tick(10);

      // Randomised underflow guard: FIFO emptiness and enable toggle freely
      decoded_q.delete();
      expect_seq.delete();
      for (int i = 0; i < 3000; i++) begin
         force_empty = ($urandom_range(0, 3) == 0);
         tx_enable   = ($urandom_range(0, 15) != 0);
         if ($urandom_range(0, 19) == 0 && fifo_q.size() < 4) begin
            rb = 8'($urandom);
            fifo_q.push_back(rb);
            expect_seq.push_back(rb);
         end
         tick(1);
      end
      force_empty = 1'b0;
      tx_enable   = 1'b1;
      k = 0;
      while ((fifo_q.size() > 0 || busy || in_frame) && k < 3000) begin
         tick(1);
         k++;
      end
      check("rand_drain", 64'(k < 3000), 64'(1));
      check("rand_count", 64'(decoded_q.size()), 64'(expect_seq.size()));
      while (decoded_q.size() > 0 && expect_seq.size() > 0)
         check("rand_byte", 64'(decoded_q.pop_front()), 64'(expect_seq.pop_front()));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
